// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction-memory fetch request/response channel
// master (sequencer): drives req_valid/req_addr, receives req_ready/rsp_valid/rsp_data
// slave (memory): the mirror image
interface core_sequencer_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/execute/writeback control for the RV32I datapath
// ports: clk, reset (sync, active-high); run/step control; imem fetch channel;
// instr/exec_en/rf_we to the datapath, branch_taken/branch_target from it;
// pc, retired, busy, halted, fault status
module core_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  core_sequencer_if.master  imem,
  output logic [31:0]       instr,
  output logic              exec_en,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  output logic              rf_we,
  output logic [XLEN-1:0]   pc,
  output logic [31:0]       retired,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        fault
);
  typedef enum logic [2:0] {IDLE, FETCH_REQ, FETCH_WAIT, EXECUTE, WRITEBACK, HALTED} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] target, tgt;
  logic [6:0] opc;
  logic legal, sys, mis, sstep;
  logic [1:0] efault;
  always_comb begin
    opc = instr[6:0];
    legal = opc inside {7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                        7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
    sys = opc == 7'b1110011;
    tgt = branch_taken ? branch_target : pc + XLEN'(4);
    mis = tgt[1:0] != 2'b00;
    efault = sys ? 2'b00 : !legal ? 2'b01 : mis ? 2'b10 : 2'b00;
    nxt = state;
    case (state)
      IDLE:       nxt = (run || step) ? FETCH_REQ : IDLE;
      FETCH_REQ:  nxt = imem.req_ready ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: nxt = imem.rsp_valid ? EXECUTE : FETCH_WAIT;
      EXECUTE:    nxt = (sys || !legal || mis) ? HALTED : WRITEBACK;
      WRITEBACK:  nxt = (run && !sstep) ? FETCH_REQ : IDLE;
      default:    nxt = HALTED;
    endcase
  end
  assign imem.req_valid = state == FETCH_REQ;
  assign imem.req_addr  = pc;
  assign exec_en = state == EXECUTE;
  assign rf_we   = state == WRITEBACK && opc != 7'b1100011 && opc != 7'b0100011 && instr[11:7] != 5'd0;
  assign busy    = state != IDLE && state != HALTED;
  assign halted  = state == HALTED;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
      fault   <= 2'b00;
      target  <= RESET_PC;
      sstep   <= 1'b0;
    end else begin
      state <= nxt;
      // run wins over step, so only a step taken with run low is single-step
      if (state == IDLE && (run || step)) sstep <= !run;
      if (state == FETCH_WAIT && imem.rsp_valid) instr <= imem.rsp_data;
      if (state == EXECUTE) begin
        target <= tgt;
        fault  <= efault;
      end
      if (state == WRITEBACK) begin
        pc      <= target;
        retired <= retired + 32'd1;
      end
    end
  end
endmodule
